irq_prio_ctrl: RTL and testbench

//  Parametrised, clocked successor to the 27-channel combinational interrupt priority decoder.

---
 rtl/irq_prio_ctrl.sv | 107 ++++++++++
 tb/tb_irq_prio_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// Clocked interrupt priority controller: latched pending register, programmable mask,
// and a lowest-index-wins winner presented through a registered valid/ack handshake.
module irq_prio_ctrl #(
   parameter int unsigned NUM_CH    = 27,
   parameter int unsigned ID_W      = 5,
   parameter bit          EDGE_MODE = 1'b0,
   parameter bit          MASK_RST  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              mask_we_i,
   input  logic [NUM_CH-1:0] mask_wdata_i,
   output logic              irq_valid_o,
   output logic [ID_W-1:0]   irq_id_o,
   input  logic              irq_ack_i,
   output logic [NUM_CH-1:0] pending_o,
   output logic [NUM_CH-1:0] mask_o
);

   typedef enum logic [0:0] {StIdle, StPresent} state_e;

   state_e            state_q, state_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] req_q;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic              irq_valid_q, irq_valid_d;
   logic [ID_W-1:0]   irq_id_q, irq_id_d;

   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] sel_onehot;
   logic [NUM_CH-1:0] set_vec;
   logic [NUM_CH-1:0] clr_vec;
   logic [ID_W-1:0]   winner;
   logic              ack_fire;
   logic              sel_ok;

   assign eligible   = pending_q & ~mask_q;
   assign ack_fire   = irq_valid_q & irq_ack_i;
   assign sel_onehot = NUM_CH'(1) << irq_id_q;
   // Presented channel is still pending and unmasked; otherwise it is withdrawn.
   assign sel_ok     = |(eligible & sel_onehot);
   assign set_vec    = req_i & ~req_q;
   assign clr_vec    = ack_fire ? sel_onehot : '0;

   always_comb begin
      winner = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end
   end

   always_comb begin
      if (EDGE_MODE) pending_d = set_vec | (pending_q & ~clr_vec);
      else           pending_d = req_i;
      mask_d = mask_we_i ? mask_wdata_i : mask_q;
   end

   always_comb begin
      state_d     = state_q;
      irq_valid_d = irq_valid_q;
      irq_id_d    = irq_id_q;
      unique case (state_q)
         StIdle: begin
            if (|eligible) begin
               state_d     = StPresent;
               irq_valid_d = 1'b1;
               irq_id_d    = winner;
            end
         end
         StPresent: begin
            if (ack_fire || !sel_ok) begin
               state_d     = StIdle;
               irq_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = StIdle;
            irq_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         pending_q   <= '0;
         req_q       <= '0;
         mask_q      <= {NUM_CH{MASK_RST}};
         irq_valid_q <= 1'b0;
         irq_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         req_q       <= req_i;
         mask_q      <= mask_d;
         irq_valid_q <= irq_valid_d;
         irq_id_q    <= irq_id_d;
      end
   end

   assign irq_valid_o = irq_valid_q;
   assign irq_id_o    = irq_id_q;
   assign pending_o   = pending_q;
   assign mask_o      = mask_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench for irq_prio_ctrl: one edge-mode and one level-mode instance,
// expected ids queued at stimulus time and popped when each instance presents.
module tb_irq_prio_ctrl;

   localparam int N = 27;

   logic         clk, rst_n;
   logic [N-1:0] req_e, mwd_e, pend_e, mask_e;
   logic [N-1:0] req_l, mwd_l, pend_l, mask_l;
   logic         mwe_e, ack_e, valid_e;
   logic         mwe_l, ack_l, valid_l;
   logic [4:0]   id_e, id_l;

   int exp_e[$];
   int exp_l[$];
   int n_vec = 0;
   int n_err = 0;

   irq_prio_ctrl #(.NUM_CH(N), .ID_W(5), .EDGE_MODE(1'b1), .MASK_RST(1'b0)) dut_e (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_e),
      .mask_we_i    (mwe_e),
      .mask_wdata_i (mwd_e),
      .irq_valid_o  (valid_e),
      .irq_id_o     (id_e),
      .irq_ack_i    (ack_e),
      .pending_o    (pend_e),
      .mask_o       (mask_e)
   );

   irq_prio_ctrl #(.NUM_CH(N), .ID_W(5), .EDGE_MODE(1'b0), .MASK_RST(1'b0)) dut_l (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_l),
      .mask_we_i    (mwe_l),
      .mask_wdata_i (mwd_l),
      .irq_valid_o  (valid_l),
      .irq_id_o     (id_l),
      .irq_ack_i    (ack_l),
      .pending_o    (pend_l),
      .mask_o       (mask_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a presentation, check its latency in edges, then pop the expected id.
   task automatic wait_irq(input bit lvl, input int lat, input string tag);
      int   n;
      int   exp_id;
      logic v;
      n = 0;
      v = lvl ? valid_l : valid_e;
      while (!v && n < 8) begin
         step();
         n++;
         v = lvl ? valid_l : valid_e;
      end
      check_eq({tag, "_lat"}, 64'(n), 64'(lat));
      if (lvl) begin
         if (exp_l.size() == 0) check_eq({tag, "_sb"}, 64'(0), 64'(1));
         else begin
            exp_id = exp_l.pop_front();
            check_eq({tag, "_id"}, 64'(id_l), 64'(exp_id));
         end
      end else begin
         if (exp_e.size() == 0) check_eq({tag, "_sb"}, 64'(0), 64'(1));
         else begin
            exp_id = exp_e.pop_front();
            check_eq({tag, "_id"}, 64'(id_e), 64'(exp_id));
         end
      end
   endtask

   task automatic ack_once(input bit lvl, input string tag);
      if (lvl) ack_l = 1'b1;
      else     ack_e = 1'b1;
      step();
      ack_l = 1'b0;
      ack_e = 1'b0;
      check_eq({tag, "_bubble"}, 64'(lvl ? valid_l : valid_e), 64'(0));
   endtask

   task automatic pulse_e(input int ch, input bit expect_present);
      req_e = N'(1) << ch;
      if (expect_present) exp_e.push_back(ch);
      step();
      req_e = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      req_e = '0; mwd_e = '0; mwe_e = 1'b0; ack_e = 1'b0;
      req_l = '0; mwd_l = '0; mwe_l = 1'b0; ack_l = 1'b0;
      #2;
      check_eq("rst_valid", 64'(valid_e), 64'(0));
      check_eq("rst_id", 64'(id_e), 64'(0));
      check_eq("rst_pend", 64'(pend_e), 64'(0));
      check_eq("rst_mask", 64'(mask_e), 64'(0));
      #10 rst_n = 1'b1;
      step();

      // Simultaneous pulses: lower index first, then the other after a bubble.
      req_e = (N'(1) << 5) | (N'(1) << 2);
      exp_e.push_back(2);
      exp_e.push_back(5);
      step();
      req_e = '0;
      check_eq("prio_pend", 64'(pend_e), 64'(32'h24));
      check_eq("prio_valid0", 64'(valid_e), 64'(0));
      wait_irq(1'b0, 1, "prio_a");
      ack_once(1'b0, "prio_a");
      wait_irq(1'b0, 1, "prio_b");
      ack_once(1'b0, "prio_b");
      step();
      check_eq("prio_idle", 64'(valid_e), 64'(0));

      // Held presentation ignores a higher-priority arrival.
      pulse_e(9, 1'b1);
      wait_irq(1'b0, 1, "hold_a");
      pulse_e(1, 1'b1);
      check_eq("hold_id1", 64'(id_e), 64'(9));
      step();
      check_eq("hold_id2", 64'(id_e), 64'(9));
      check_eq("hold_valid", 64'(valid_e), 64'(1));
      ack_once(1'b0, "hold_a");
      wait_irq(1'b0, 1, "hold_b");
      ack_once(1'b0, "hold_b");

      // Masked channel stays pending but is not presented until unmasked.
      mwe_e = 1'b1; mwd_e = N'(1) << 3;
      step();
      mwe_e = 1'b0;
      check_eq("mask_reg", 64'(mask_e), 64'(8));
      pulse_e(3, 1'b0);
      check_eq("mask_pend3", 64'(pend_e[3]), 64'(1));
      step();
      check_eq("mask_novalid1", 64'(valid_e), 64'(0));
      step();
      check_eq("mask_novalid2", 64'(valid_e), 64'(0));
      mwe_e = 1'b1; mwd_e = '0;
      exp_e.push_back(3);
      step();
      mwe_e = 1'b0;
      wait_irq(1'b0, 1, "unmask");
      ack_once(1'b0, "unmask");

      // Ack and a new rising edge on the same channel in the same cycle: set wins.
      pulse_e(4, 1'b1);
      wait_irq(1'b0, 1, "race_a");
      ack_e = 1'b1;
      req_e = N'(1) << 4;
      exp_e.push_back(4);
      step();
      ack_e = 1'b0;
      req_e = '0;
      check_eq("race_bubble", 64'(valid_e), 64'(0));
      check_eq("race_pend4", 64'(pend_e[4]), 64'(1));
      wait_irq(1'b0, 1, "race_b");
      ack_once(1'b0, "race_b");
      check_eq("race_pend_clr", 64'(pend_e), 64'(0));

      // Masking the presented channel withdraws it without an ack.
      pulse_e(6, 1'b1);
      wait_irq(1'b0, 1, "wd_a");
      mwe_e = 1'b1; mwd_e = N'(1) << 6;
      step();
      mwe_e = 1'b0;
      check_eq("wd_held", 64'(valid_e), 64'(1));
      step();
      check_eq("wd_drop", 64'(valid_e), 64'(0));
      check_eq("wd_pend6", 64'(pend_e[6]), 64'(1));
      mwe_e = 1'b1; mwd_e = '0;
      exp_e.push_back(6);
      step();
      mwe_e = 1'b0;
      wait_irq(1'b0, 1, "wd_b");
      ack_once(1'b0, "wd_b");

      // Level mode: held request re-presents after each ack; dropping it withdraws.
      req_l = N'(1);
      exp_l.push_back(0);
      step();
      wait_irq(1'b1, 1, "lvl_a");
      exp_l.push_back(0);
      ack_once(1'b1, "lvl_a");
      wait_irq(1'b1, 1, "lvl_b");
      exp_l.push_back(0);
      ack_once(1'b1, "lvl_b");
      wait_irq(1'b1, 1, "lvl_c");
      req_l = '0;
      step();
      check_eq("lvl_held", 64'(valid_l), 64'(1));
      step();
      check_eq("lvl_withdraw", 64'(valid_l), 64'(0));
      check_eq("lvl_pend", 64'(pend_l), 64'(0));

      // Asynchronous reset mid-cycle while presenting.
      mwe_e = 1'b1; mwd_e = N'(1) << 20;
      step();
      mwe_e = 1'b0;
      pulse_e(7, 1'b1);
      wait_irq(1'b0, 1, "arst");
      #3 rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 64'(valid_e), 64'(0));
      check_eq("arst_pend", 64'(pend_e), 64'(0));
      check_eq("arst_mask", 64'(mask_e), 64'(0));
      check_eq("arst_id", 64'(id_e), 64'(0));
      #2 rst_n = 1'b1;
      step();
      step();
      check_eq("arst_lost", 64'(valid_e), 64'(0));

      check_eq("sb_empty_e", 64'(exp_e.size()), 64'(0));
      check_eq("sb_empty_l", 64'(exp_l.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
